// File: rtl/rc4_stream_ctrl.sv
// RC4 sequencer: drives a 256x8 S-box RAM through INIT, key scheduling and
// keystream generation, and emits keystream bytes on a valid/ready stream.
module rc4_stream_ctrl #(
    parameter int KEY_BYTES = 16,
    localparam int KL_W = $clog2(KEY_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic [KL_W-1:0]        key_len,
    output logic                   busy,
    output logic                   ks_valid,
    input  logic                   ks_ready,
    output logic [7:0]             ks_data,
    output logic                   ram_wen,
    output logic [7:0]             ram_raddr_1,
    input  logic [7:0]             ram_rdata_1,
    output logic [7:0]             ram_waddr_2,
    output logic [7:0]             ram_wdata_2,
    output logic [7:0]             ram_addr_3,
    output logic [7:0]             ram_wdata_3,
    input  logic [7:0]             ram_rdata_3,
    output logic [2:0]             dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_KSA_A  = 3'd2;
    localparam logic [2:0] S_KSA_B  = 3'd3;
    localparam logic [2:0] S_PRGA_1 = 3'd4;
    localparam logic [2:0] S_PRGA_2 = 3'd5;
    localparam logic [2:0] S_PRGA_3 = 3'd6;
    localparam logic [2:0] S_OUT    = 3'd7;

    logic [2:0]             r_state;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [7:0]             r_t;
    logic [7:0]             r_si;
    logic [7:0]             r_ks_data;
    logic                   r_ks_valid;
    logic [KL_W-1:0]        r_kidx;
    logic [KL_W-1:0]        r_key_len;
    logic [KEY_BYTES*8-1:0] r_key;

    logic [7:0]      w_key_byte;
    logic [KL_W-1:0] w_kidx_next;
    logic [KL_W-1:0] w_key_len_eff;
    logic            w_wen;
    logic [7:0]      w_raddr_1;
    logic [7:0]      w_waddr_2;
    logic [7:0]      w_wdata_2;
    logic [7:0]      w_addr_3;
    logic [7:0]      w_wdata_3;

    always_comb begin
        w_key_byte = '0;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (r_kidx == KL_W'(n)) w_key_byte = r_key[8*n +: 8];
        end
    end

    // Key index wraps by comparison against the captured length, not by modulo.
    assign w_kidx_next   = (r_kidx == r_key_len - KL_W'(1)) ? '0 : r_kidx + KL_W'(1);
    assign w_key_len_eff = (key_len == '0 || key_len > KL_W'(KEY_BYTES)) ? KL_W'(KEY_BYTES) : key_len;

    always_comb begin
        w_wen     = 1'b0;
        w_raddr_1 = '0;
        w_waddr_2 = '0;
        w_wdata_2 = '0;
        w_addr_3  = '0;
        w_wdata_3 = '0;
        case (r_state)
            S_INIT: begin
                w_wen     = 1'b1;
                w_waddr_2 = r_i;
                w_wdata_2 = r_i;
                w_addr_3  = r_i + 8'd128;
                w_wdata_3 = r_i + 8'd128;
            end
            S_KSA_A:  w_raddr_1 = r_i;
            // Swap: port 3 reads S[j] and writes S[i] there; port 2 stores S[j] at i.
            S_KSA_B, S_PRGA_2: begin
                w_wen     = 1'b1;
                w_waddr_2 = r_i;
                w_wdata_2 = ram_rdata_3;
                w_addr_3  = r_j;
                w_wdata_3 = r_si;
            end
            S_PRGA_1: w_raddr_1 = r_i + 8'd1;
            S_PRGA_3: w_raddr_1 = r_t;
            default: ;
        endcase
    end

    assign ram_wen     = w_wen & ~stop;
    assign ram_raddr_1 = w_raddr_1;
    assign ram_waddr_2 = w_waddr_2;
    assign ram_wdata_2 = w_wdata_2;
    assign ram_addr_3  = w_addr_3;
    assign ram_wdata_3 = w_wdata_3;
    assign busy        = (r_state != S_IDLE);
    assign ks_valid    = r_ks_valid;
    assign ks_data     = r_ks_data;
    assign dbg_state   = r_state;

    // Stream: a byte transfers on a rising edge where ks_valid && ks_ready;
    // ks_data/ks_valid stay frozen until then unless stop or rst intervenes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_t        <= '0;
            r_si       <= '0;
            r_ks_data  <= '0;
            r_ks_valid <= 1'b0;
            r_kidx     <= '0;
            r_key_len  <= '0;
            r_key      <= '0;
        end else if (stop) begin
            r_state    <= S_IDLE;
            r_ks_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_key     <= key;
                        r_key_len <= w_key_len_eff;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_kidx    <= '0;
                        r_state   <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (r_i == 8'd127) begin
                        r_i     <= '0;
                        r_state <= S_KSA_A;
                    end else begin
                        r_i <= r_i + 8'd1;
                    end
                end
                S_KSA_A: begin
                    r_si    <= ram_rdata_1;
                    r_j     <= r_j + ram_rdata_1 + w_key_byte;
                    r_state <= S_KSA_B;
                end
                S_KSA_B: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= w_kidx_next;
                    if (r_i == 8'd255) begin
                        r_j     <= '0;
                        r_state <= S_PRGA_1;
                    end else begin
                        r_state <= S_KSA_A;
                    end
                end
                S_PRGA_1: begin
                    r_i     <= r_i + 8'd1;
                    r_si    <= ram_rdata_1;
                    r_j     <= r_j + ram_rdata_1;
                    r_state <= S_PRGA_2;
                end
                S_PRGA_2: begin
                    r_t     <= r_si + ram_rdata_3;
                    r_state <= S_PRGA_3;
                end
                S_PRGA_3: begin
                    r_ks_data  <= ram_rdata_1;
                    r_ks_valid <= 1'b1;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    if (r_ks_valid && ks_ready) begin
                        r_ks_valid <= 1'b0;
                        r_state    <= S_PRGA_1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Bench for rc4_stream_ctrl: behavioural RAM, plain-arithmetic RC4 reference,
// per-cycle stream scoreboard and directed session scenarios.
module tb_rc4_stream_ctrl;

    localparam logic [127:0] KEY_K   = 128'h79654B;
    localparam logic [127:0] KEY_W   = 128'h696B6957;
    localparam logic [127:0] KEY_S   = 128'h746572636553;
    localparam logic [127:0] KEY_16A = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [127:0] KEY_16B = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [127:0] key = '0;
    logic [4:0]   key_len = '0;
    logic         ks_ready = 1'b0;
    logic         busy, ks_valid, ram_wen;
    logic [7:0]   ks_data, ram_raddr_1, ram_rdata_1, ram_waddr_2, ram_wdata_2;
    logic [7:0]   ram_addr_3, ram_wdata_3, ram_rdata_3;
    logic [2:0]   dbg_state;

    logic [7:0] mem [256];
    logic [7:0] model_sbox [256];
    logic [7:0] model_ks [$];
    logic [7:0] exp_q [$];

    int  n_checks = 0;
    int  n_pass = 0;
    bit  stab_en = 1'b0;
    bit  bp_mode = 1'b0;
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    rc4_stream_ctrl #(.KEY_BYTES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .key(key), .key_len(key_len),
        .busy(busy), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .ram_wen(ram_wen), .ram_raddr_1(ram_raddr_1), .ram_rdata_1(ram_rdata_1),
        .ram_waddr_2(ram_waddr_2), .ram_wdata_2(ram_wdata_2), .ram_addr_3(ram_addr_3),
        .ram_wdata_3(ram_wdata_3), .ram_rdata_3(ram_rdata_3), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign ram_rdata_1 = mem[ram_raddr_1];
    assign ram_rdata_3 = mem[ram_addr_3];
    always @(posedge clk) begin
        if (ram_wen) begin
            mem[ram_waddr_2] <= ram_wdata_2;
            mem[ram_addr_3]  <= ram_wdata_3;
        end
    end

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    endtask

    // Textbook RC4 on int arrays: KSA then n PRGA output bytes.
    task automatic rc4_model(input logic [127:0] k, input int len, input int n);
        int s [256];
        int kb [16];
        int l, i, j, tmp;
        l = (len == 0 || len > 16) ? 16 : len;
        for (int b = 0; b < 16; b++) kb[b] = int'(k[8*b +: 8]);
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + kb[x % l]) % 256;
            tmp = s[x]; s[x] = s[j]; s[j] = tmp;
        end
        for (int x = 0; x < 256; x++) model_sbox[x] = 8'(s[x]);
        model_ks.delete();
        i = 0;
        j = 0;
        repeat (n) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            model_ks.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
    endtask

    task automatic pin_model(input string name, input int n, input logic [79:0] v);
        for (int x = 0; x < n; x++) check(name, int'(model_ks[x]), int'(v[8*(n-1-x) +: 8]));
    endtask

    // Random back-pressure: ks_ready high about 30% of cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) ks_ready = ($urandom_range(0, 9) < 3);
        end
    end

    always @(negedge clk) begin
        logic [7:0] want;
        if (ks_valid && ks_ready && exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("ks_data", int'(ks_data), int'(want));
        end
        if (stab_en && prev_v && !prev_r) begin
            check("hold_valid", int'(ks_valid), 1);
            check("hold_data", int'(ks_data), int'(prev_d));
        end
        prev_v = ks_valid;
        prev_r = ks_ready;
        prev_d = ks_data;
    end

    task automatic pulse_start(input logic [127:0] k, input int len);
        @(posedge clk);
        #1;
        key = k;
        key_len = 5'(len);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_session(input logic [127:0] k, input int len, input int nbytes,
                               input bit spurious, input bit bp);
        int first_valid;
        int wen_cnt;
        int mism;
        int guard;
        rc4_model(k, len, nbytes);
        foreach (model_ks[x]) exp_q.push_back(model_ks[x]);
        if (!bp) ks_ready = 1'b1;
        stab_en = bp;
        bp_mode = bp;
        pulse_start(k, len);
        first_valid = -1;
        wen_cnt = 0;
        mism = 0;
        for (int kk = 0; kk < 700 && first_valid < 0; kk++) begin
            @(negedge clk);
            if (kk < 640 && ram_wen) wen_cnt++;
            if (kk == 640) begin
                for (int a = 0; a < 256; a++) if (mem[a] != model_sbox[a]) mism++;
            end
            if (ks_valid) first_valid = kk;
            if (spurious) begin
                if (kk == 50 || kk == 300 || kk == 641) begin
                    key = KEY_W;
                    key_len = 5'd4;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("first_valid_latency", first_valid, 643);
        check("wen_cycles_before_prga", wen_cnt, 384);
        check("sbox_after_ksa_mismatches", mism, 0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 100 * nbytes + 200) begin
            @(negedge clk);
            guard++;
        end
        check("stream_bytes_left", exp_q.size(), 0);
        exp_q.delete();
        stab_en = 1'b0;
        bp_mode = 1'b0;
        @(posedge clk);
        #1;
        ks_ready = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_valid", int'(ks_valid), 0);
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(ks_valid), 0);
        check("rst_data", int'(ks_data), 0);
        check("rst_wen", int'(ram_wen), 0);
        check("rst_raddr1", int'(ram_raddr_1), 0);
        check("rst_waddr2", int'(ram_waddr_2), 0);
        check("rst_wdata2", int'(ram_wdata_2), 0);
        check("rst_addr3", int'(ram_addr_3), 0);
        check("rst_wdata3", int'(ram_wdata_3), 0);
        check("rst_state", int'(dbg_state), 0);
        rst = 1'b0;

        rc4_model(KEY_K, 3, 10);
        pin_model("model_key", 10, 80'hEB9F7781B734CA72A719);
        rc4_model(KEY_W, 4, 6);
        pin_model("model_wiki", 6, 80'h6044DB6D41B7);
        rc4_model(KEY_S, 6, 8);
        pin_model("model_secret", 8, 80'h04D46B053CA87B59);

        run_session(KEY_K, 3, 10, 1'b0, 1'b0);
        run_session(KEY_W, 4, 6, 1'b0, 1'b0);
        run_session(KEY_S, 6, 8, 1'b0, 1'b0);
        run_session(KEY_K, 3, 10, 1'b0, 1'b1);
        run_session(KEY_K, 3, 10, 1'b1, 1'b0);
        run_session(KEY_16A, 0, 8, 1'b0, 1'b0);
        run_session(KEY_16B, 31, 8, 1'b0, 1'b0);

        // Abort in the first KSA_B cycle, then restart.
        pulse_start(KEY_K, 3);
        for (int kk = 0; kk < 130; kk++) @(negedge clk);
        check("ksa_b_wen_before_stop", int'(ram_wen), 1);
        stop = 1'b1;
        #1;
        check("stop_cycle_wen", int'(ram_wen), 0);
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("stop_next_busy", int'(busy), 0);
        run_session(KEY_K, 3, 10, 1'b0, 1'b0);

        // Asynchronous reset in the middle of PRGA, then restart.
        ks_ready = 1'b1;
        pulse_start(KEY_K, 3);
        guard = 0;
        while (!ks_valid && guard < 700) begin
            @(negedge clk);
            guard++;
        end
        check("rst_test_reached_prga", int'(ks_valid), 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(ks_valid), 0);
        check("mid_rst_wen", int'(ram_wen), 0);
        check("mid_rst_data", int'(ks_data), 0);
        @(negedge clk);
        rst = 1'b0;
        run_session(KEY_K, 3, 10, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rc4_stream_ctrl.md
Name: rc4_stream_ctrl

Overview:
- Sequencer for the RC4 S-box RAM (256x8, combinational read on ports 1 and 3, one shared synchronous write enable for ports 2 and 3).
- Runs three phases: S-box initialisation (INIT), key scheduling (KSA) and keystream generation (PRGA).
- Delivers keystream bytes on a valid/ready stream.
- Sits between the cipher top-level and the S-box RAM. It is the only master of the RAM's address and write ports.

Parameters:
- KEY_BYTES, 16, maximum key length in bytes; key bus is KEY_BYTES*8 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- stop  input  1  abort request; returns to IDLE at next edge from any state.
- key  input  KEY_BYTES*8  key; byte n at key[8n+7:8n]; captured on accepted start.
- key_len  input  $clog2(KEY_BYTES+1)  key length in bytes; captured on accepted start.
- busy  output  1  high in every state except IDLE.
- ks_valid  output  1  keystream byte available.
- ks_ready  input  1  consumer accepts ks_data when ks_valid&&ks_ready.
- ks_data  output  8  keystream byte.
- ram_wen  output  1  write enable for both RAM write ports.
- ram_raddr_1  output  8  RAM read-only port address.
- ram_rdata_1  input  8  RAM port-1 read data (combinational).
- ram_waddr_2  output  8  RAM write-only port address.
- ram_wdata_2  output  8  RAM port-2 write data.
- ram_addr_3  output  8  RAM read/write port address.
- ram_wdata_3  output  8  RAM port-3 write data.
- ram_rdata_3  input  8  RAM port-3 read data (combinational).

Behaviour:
- Reset (async):
  - state=IDLE; i, j, kidx, t, si=0; busy=0, ks_valid=0, ks_data=0, ram_wen=0.
  - All RAM address/data outputs are 0.
  - RAM contents are not relied upon after reset; INIT always rewrites them.
- Key capture: key_len==0 or key_len>KEY_BYTES is captured as KEY_BYTES. start while busy is ignored.
- Arithmetic: all index arithmetic is 8-bit modulo 256. kidx wraps to 0 when kidx+1==key_len; no divider is used.
- IDLE: on start, capture key and key_len, clear i, j, kidx, go to INIT.
- INIT (128 cycles):
  - ram_wen=1; port 2 writes S[i]=i; port 3 writes S[i+128]=i+128.
  - i increments each cycle. After i==127: i=0, go to KSA_A.
- KSA_A:
  - ram_raddr_1=i; latch si=ram_rdata_1.
  - j <= j+si+keybyte[kidx].
  - Go to KSA_B.
- KSA_B:
  - ram_addr_3=j; ram_wen=1.
  - Port 2 writes ram_rdata_3 at address i; port 3 writes si at address j.
  - i==j is legal: both ports write the same value to the same address.
  - i++, kidx advances. If i was 255: i=0, j=0, go to PRGA_1. Otherwise go to KSA_A.
- PRGA_1:
  - ram_raddr_1=i+1; i<=i+1; si=ram_rdata_1; j<=j+ram_rdata_1.
  - Go to PRGA_2.
- PRGA_2:
  - ram_addr_3=j; swap as in KSA_B (port 2 at i gets ram_rdata_3, port 3 at j gets si).
  - t<=si+ram_rdata_3. Go to PRGA_3.
- PRGA_3:
  - ram_raddr_1=t; ks_data<=ram_rdata_1; ks_valid<=1.
  - Go to OUT.
- OUT:
  - ks_data and ks_valid hold stable until the handshake.
  - On ks_valid&&ks_ready: ks_valid<=0, go to PRGA_1.
  - Throughput with ks_ready constantly high: one byte per 4 cycles.
- ram_wen is 1 only in INIT, KSA_B and PRGA_2; it is 0 in all other states.
- stop has priority over every transition:
  - next state is IDLE, ks_valid<=0.
  - ram_wen is forced to 0 combinationally in the stop cycle, so no partial swap occurs.
  - The S-box is not consistent afterwards; a fresh start is required.
- Latency: start accepted at edge E0 -> INIT covers E1..E128, KSA covers E129..E640, first ks_valid high after E643.
- Reset mid-operation: immediate IDLE, all outputs at reset values. A partial RAM write cannot occur after rst rises.

Test Plan:
- Reset then start, key="Key" (0x4B,0x65,0x79), key_len=3, ks_ready=1 -> ks_valid first high 643 cycles after start; bytes EB 9F 77 81 B7 34 CA 72 A7 19.
- key="Wiki", key_len=4 -> 60 44 DB 6D 41 B7. key="Secret", key_len=6 -> 04 D4 6B 05 3C A8 7B 59.
- Back-pressure: random ks_ready (~30% high), key="Key" -> identical byte sequence; ks_data and ks_valid never change while ks_valid&&!ks_ready.
- start pulses during INIT/KSA/PRGA -> ignored; sequence unchanged. key_len=0 with KEY_BYTES=16 -> output matches a software model using a 16-byte key.
- stop asserted in KSA_B, then start with "Key" -> ram_wen=0 in the stop cycle, IDLE next cycle, correct "Key" keystream afterwards. rst pulsed during PRGA -> busy=0 and ks_valid=0 immediately; restart yields correct stream.
- Checker after KSA with "Key": model-compare all 256 S-box entries; verify ram_wen asserts in exactly 128+256 cycles before first PRGA.
